// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer driving adr_gen and one word-wide synchronous RAM.
// Optional: define MARCH_STOP_ON_FAIL_EN to end the test at the first mismatch.
module march_bist_ctrl #(
  parameter int ADR_SIZE = 4,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                adr_rst,
  output logic                adr_preset,
  output logic                adr_en,
  output logic                adr_up,
  input  logic                adr_last,
  input  logic [ADR_SIZE-1:0] adr,
  output logic                mem_we,
  output logic                mem_re,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [ADR_SIZE-1:0] fail_adr,
  output logic [2:0]          fail_elem
);

  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                vld;
    logic                bg;
    logic [ADR_SIZE-1:0] adr;
    logic [2:0]          elem;
  } cmp_t;

  state_t     state, state_nxt;
  logic [2:0] elem, elem_nxt;
  logic       op_idx, op_idx_nxt;
  logic       last_flag;
  logic       clr_fail;
  cmp_t       cmp_q;

  logic one_op, last_op, op_rd, bg_bit, elem_up, at_end, mismatch;

  // Element op table: elem 0 = w0, elem 5 = r0, elems 1-4 = read then write of
  // the opposite background; elems 2 and 4 start from the all-ones background.
  assign one_op   = (elem == 3'd0) || (elem == 3'd5);
  assign last_op  = one_op || op_idx;
  assign op_rd    = (elem != 3'd0) && !op_idx;
  assign bg_bit   = !one_op && (op_idx ^ ((elem == 3'd2) || (elem == 3'd4)));
  assign elem_up  = !((elem == 3'd3) || (elem == 3'd4));

  // c_out can arrive on the very cycle of the last op, so the transition looks
  // at it directly; adr_en uses only the latched flag to stay register-driven.
  assign at_end   = last_flag || adr_last;
  assign mismatch = cmp_q.vld && (mem_rdata != {DATA_W{cmp_q.bg}});

  always_comb begin
    busy       = (state == SETUP) || (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
    adr_up     = ((state == SETUP) || (state == RUN)) && elem_up;
    adr_rst    = (state == SETUP) && elem_up;
    adr_preset = (state == SETUP) && !elem_up;
    mem_we     = (state == RUN) && !op_rd;
    mem_re     = (state == RUN) && op_rd;
    mem_wdata  = mem_we ? {DATA_W{bg_bit}} : '0;
    adr_en     = (state == RUN) && last_op && !last_flag;
  end

  always_comb begin
    state_nxt  = state;
    elem_nxt   = elem;
    op_idx_nxt = op_idx;
    clr_fail   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SETUP;
          elem_nxt  = 3'd0;
          clr_fail  = 1'b1;
        end
      end
      SETUP: begin
        state_nxt  = RUN;
        op_idx_nxt = 1'b0;
      end
      RUN: begin
        if (last_op) begin
          op_idx_nxt = 1'b0;
          if (at_end) begin
            if (elem == 3'd5) begin
              state_nxt = DRAIN;
            end else begin
              state_nxt = SETUP;
              elem_nxt  = 3'(elem + 3'd1);
            end
          end
        end else begin
          op_idx_nxt = 1'b1;
        end
      end
      DRAIN: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
`ifdef MARCH_STOP_ON_FAIL_EN
    if (((state == RUN) || (state == DRAIN)) && mismatch) state_nxt = DONE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      elem   <= 3'd0;
      op_idx <= 1'b0;
    end else begin
      state  <= state_nxt;
      elem   <= elem_nxt;
      op_idx <= op_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_flag <= 1'b0;
    end else if (state == SETUP) begin
      last_flag <= 1'b0;
    end else if ((state == RUN) && adr_last) begin
      last_flag <= 1'b1;
    end
  end

  // Read expectation travels one cycle alongside the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= '0;
    end else begin
      cmp_q.vld  <= mem_re;
      cmp_q.bg   <= bg_bit;
      cmp_q.adr  <= adr;
      cmp_q.elem <= elem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= 3'd0;
    end else if (clr_fail) begin
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= 3'd0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_adr  <= cmp_q.adr;
        fail_elem <= cmp_q.elem;
      end
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl with behavioural adr_gen and faultable 16x8 RAM.
module tb_march_bist_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef MARCH_STOP_ON_FAIL_EN
  localparam int STOP = 1;
`else
  localparam int STOP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          adr_rst, adr_preset, adr_en, adr_up, adr_last;
  logic [AW-1:0] adr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_adr;
  logic [2:0]    fail_elem;

  int errs = 0;
  int checks = 0;
  int fault = 0;

  always #5 clk = ~clk;

  march_bist_ctrl #(.ADR_SIZE(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .adr_rst(adr_rst), .adr_preset(adr_preset), .adr_en(adr_en), .adr_up(adr_up),
    .adr_last(adr_last), .adr(adr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail), .fail_adr(fail_adr), .fail_elem(fail_elem)
  );

  // adr_gen model: c_out pulses one cycle on arrival at the end address
  logic [AW-1:0] ag_nxt;
  assign ag_nxt = adr_up ? AW'(adr + 1'b1) : AW'(adr - 1'b1);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr <= '0; adr_last <= 1'b0;
    end else if (adr_rst) begin
      adr <= '0; adr_last <= 1'b0;
    end else if (adr_preset) begin
      adr <= '1; adr_last <= 1'b0;
    end else if (adr_en) begin
      adr <= ag_nxt;
      adr_last <= adr_up ? (ag_nxt == '1) : (ag_nxt == '0);
    end else begin
      adr_last <= 1'b0;
    end
  end

  // RAM: fault 1 = bit0 stuck-at-1 at addr 5; fault 2 = writing ones to 9 inverts 10
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[adr] <= (fault == 1 && adr == 4'd5) ? (mem_wdata | 8'h01) : mem_wdata;
      if (fault == 2 && adr == 4'd9 && mem_wdata == 8'hFF) ram[10] <= ~ram[10];
    end
    if (mem_re) mem_rdata <= ram[adr];
  end

  // Activity monitor, sampled on the falling edge
  logic mon_clr = 1'b0;
  int setups, r0e1, r0e5, seq_err, rw_err, en1, en3, wf, e1i, e3i, cur, prv_elem;
  logic prv_re;
  logic [AW-1:0] prv_adr;
  assign cur = setups - 1;
  always @(negedge clk) begin
    if (mon_clr) begin
      setups <= 0; r0e1 <= 0; r0e5 <= 0; seq_err <= 0; rw_err <= 0;
      en1 <= 0; en3 <= 0; wf <= 0; e1i <= 0; e3i <= 0; prv_re <= 1'b0;
      prv_elem <= -1; prv_adr <= '0;
    end else if (rst_n) begin
      if (adr_rst || adr_preset) setups <= setups + 1;
      if (prv_re && mem_rdata == 8'h00 && prv_elem == 1) r0e1 <= r0e1 + 1;
      if (prv_re && mem_rdata == 8'h00 && prv_elem == 5) r0e5 <= r0e5 + 1;
      if (mem_re && cur == 1) begin
        if (adr != AW'(e1i)) seq_err <= seq_err + 1;
        e1i <= e1i + 1;
      end
      if (mem_re && cur == 3) begin
        if (adr != AW'(15 - e3i)) seq_err <= seq_err + 1;
        e3i <= e3i + 1;
      end
      if (mem_we && cur >= 1 && cur <= 4 && !(prv_re && prv_adr == adr)) rw_err <= rw_err + 1;
      if (adr_en && cur == 1) en1 <= en1 + 1;
      if (adr_en && cur == 3) en3 <= en3 + 1;
      if (mem_we && fail) wf <= wf + 1;
      prv_re <= mem_re; prv_adr <= adr; prv_elem <= cur;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse (or hold) start from a falling edge and count edges until done
  task automatic run(input int hold, output int cyc);
    @(posedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    start = 1'b1;
    cyc = 0;
    forever begin
      @(posedge clk); cyc++;
      #1 if (!hold) start = 1'b0;
      @(negedge clk);
      if (done) break;
      if (cyc > 400) begin
        chk("done_timeout", 32'(cyc), 32'd168);
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    int f;
    int hold;
    int exp_cyc;
    logic exp_fail;
    logic [AW-1:0] exp_adr;
    logic [2:0] exp_elem;
  } vec_t;

  vec_t vt [4];
  int cyc;

  initial begin
    vt[0] = '{0, 0, 168, 1'b0, 4'd0, 3'd0};
    vt[1] = '{0, 1, 168, 1'b0, 4'd0, 3'd0};
    vt[2] = '{1, 0, STOP ? 31 : 168, 1'b1, 4'd5, 3'd1};
    vt[3] = '{2, 0, STOP ? 41 : 168, 1'b1, 4'd10, 3'd1};

    #3;
    chk("reset_outputs", 32'({adr_rst, adr_preset, adr_en, adr_up, mem_we, mem_re, mem_wdata,
                              busy, done, fail, fail_adr, fail_elem}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 32'({busy, done}), 32'd0);

    for (int i = 0; i < 4; i++) begin
      fault = vt[i].f;
      run(vt[i].hold, cyc);
      chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(vt[i].exp_cyc));
      chk($sformatf("v%0d_fail", i), 32'(fail), 32'(vt[i].exp_fail));
      chk($sformatf("v%0d_fail_adr", i), 32'(fail_adr), 32'(vt[i].exp_adr));
      chk($sformatf("v%0d_fail_elem", i), 32'(fail_elem), 32'(vt[i].exp_elem));
      chk($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd0);
      if (vt[i].f == 0) begin
        chk($sformatf("v%0d_setups", i), 32'(setups), 32'd6);
        chk($sformatf("v%0d_r0_elem1", i), 32'(r0e1), 32'd16);
        chk($sformatf("v%0d_r0_elem5", i), 32'(r0e5), 32'd16);
        chk($sformatf("v%0d_adr_seq", i), 32'(seq_err), 32'd0);
        chk($sformatf("v%0d_r_then_w", i), 32'(rw_err), 32'd0);
        chk($sformatf("v%0d_adr_en_e1", i), 32'(en1), 32'd15);
        chk($sformatf("v%0d_adr_en_e3", i), 32'(en3), 32'd15);
      end else if (STOP != 0) begin
        chk($sformatf("v%0d_we_after_fail", i), 32'(wf), 32'd0);
      end
    end

    // DONE with fail set: start restarts and clears flags next cycle
    @(negedge clk); chk("done_held", 32'({done, fail}), 32'b11);
    fault = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("restart_busy", 32'({busy, done, fail}), 32'b100);
    chk("restart_fail_adr", 32'(fail_adr), 32'd0);
    for (int n = 0; n < 400 && !done; n++) @(negedge clk);
    chk("restart_done_clean", 32'({done, fail}), 32'b10);

    // Asynchronous reset in the middle of a run
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (49) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset_outputs", 32'({adr_rst, adr_preset, adr_en, adr_up, mem_we, mem_re, mem_wdata,
                                       busy, done, fail, fail_adr, fail_elem}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk("after_reset_idle", 32'({busy, done}), 32'd0);
    run(0, cyc);
    chk("post_reset_done_cycle", 32'(cyc), 32'd168);
    chk("post_reset_fail", 32'(fail), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
